// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: serial direct-form FIR built around one shared
// multiply-accumulate unit. It evaluates one tap per cycle. It owns the
// sample delay line and a programmable coefficient register file. Samples
// come in and results go out through valid/ready handshakes.
// Optional feature macro: FIR_FLUSH_EN adds a 'flush' input. In IDLE, flush
// clears the delay line and blocks sample acceptance for that cycle.
module fir_mac_sequencer #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 4,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FIR_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic [DATA_W-1:0]        x,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ACC_W-1:0]         q,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     cfg_we,
  input  logic [$clog2(TAPS)-1:0]  cfg_addr,
  input  logic [COEF_W-1:0]        cfg_data,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] d_q [TAPS];
  logic [DATA_W-1:0] d_d [TAPS];
  logic [COEF_W-1:0] c_q [TAPS];
  logic [COEF_W-1:0] c_d [TAPS];
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  q_q, q_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;

  logic              flush_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [ACC_W-1:0]  prod_s;
  logic [ACC_W-1:0]  sum_s;

`ifdef FIR_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake qualification and the shared multiply-accumulate datapath.
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) && !flush_s;
    accept_s   = in_valid && in_ready_s;
    prod_s     = ACC_W'(d_q[idx_q]) * ACC_W'(c_q[idx_q]);
    sum_s      = acc_q + prod_s;
  end

  // Next-state logic for the sequencer, delay line and coefficient file.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    // Writes outside IDLE are dropped and flagged on the next cycle.
    cfg_err_d   = cfg_we && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // A coefficient write lands before MAC starts, so it applies to a
        // sample accepted in the same cycle.
        if (cfg_we) begin
          c_d[cfg_addr] = cfg_data;
        end else begin
          c_d = c_q;
        end
        if (flush_s) begin
          for (int i = 0; i < TAPS; i++) begin
            d_d[i] = '0;
          end
        end else if (accept_s) begin
          d_d[0] = x;
          for (int i = 1; i < TAPS; i++) begin
            d_d[i] = d_q[i-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = sum_s;
        if (idx_q == LAST_IDX) begin
          q_d         = sum_s;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        idx_d       = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any sample in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        d_q[i] <= '0;
        c_q[i] <= COEF_W'(1);
      end
      acc_q       <= '0;
      idx_q       <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign q         = q_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer. Stimulus pushes expected results into a
// scoreboard queue. A negedge monitor pops and compares them on each output
// handshake.
module tb_fir_mac_sequencer;
  localparam int TAPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] x = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] q;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [3:0] cfg_data = 4'd0;
  logic       cfg_err;
  logic       busy;
`ifdef FIR_FLUSH_EN
  logic       flush = 1'b0;
`endif

  fir_mac_sequencer dut (
    .clk(clk),
    .rst(rst),
`ifdef FIR_FLUSH_EN
    .flush(flush),
`endif
    .x(x),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .q(q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_err(cfg_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_qv[$];
  int exp_cy[$];
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: check latency when out_valid rises, check q on each output handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (exp_cy.size() == 0) begin
        chk("spurious_valid", int'(out_valid), 0);
      end else begin
        chk("latency", cyc, exp_cy[0] + TAPS);
      end
    end
    if (out_valid && out_ready && exp_qv.size() > 0) begin
      chk("q", int'(q), exp_qv[0]);
      void'(exp_qv.pop_front());
      void'(exp_cy.pop_front());
    end
    ov_prev = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int xv, input int expq, input bit track,
                      input bit we, input int wa, input int wd, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    x        = 4'(xv);
    in_valid = 1'b1;
    cfg_we   = we;
    cfg_addr = 2'(wa);
    cfg_data = 4'(wd);
    acc_cyc  = cyc + 1;
    if (track) begin
      exp_qv.push_back(expq);
      exp_cy.push_back(acc_cyc);
    end
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic wcfg(input int wa, input int wd);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    cfg_we   = 1'b1;
    cfg_addr = 2'(wa);
    cfg_data = 4'(wd);
    step();
    cfg_we = 1'b0;
    chk("cfg_err_idle", int'(cfg_err), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_qv.size() > 0 || !in_ready) && n < 200) begin
      step();
      n++;
    end
    chk("drain_pending", exp_qv.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    int xs[5];
    int qs[5];
    xs = '{1, 2, 3, 4, 0};
    qs = '{1, 3, 6, 10, 9};

    // Reset state, then idle with no activity.
    rst = 1'b0;
    step();
    step();
    chk("rst_q", int'(q), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (3) begin
      step();
      chk("idle_busy", int'(busy), 0);
      chk("idle_out_valid", int'(out_valid), 0);
    end

`ifdef FIR_FLUSH_EN
    // Flush in IDLE clears the history; a sample offered with it is not taken.
    send(1, 1, 1'b1, 1'b0, 0, 0, a0);
    send(2, 3, 1'b1, 1'b0, 0, 0, a0);
    send(3, 6, 1'b1, 1'b0, 0, 0, a0);
    drain();
    flush    = 1'b1;
    x        = 4'd9;
    in_valid = 1'b1;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", int'(busy), 0);
    send(4, 4, 1'b1, 1'b0, 0, 0, a0);
    drain();
    do_reset();
`endif

    // Default coefficients, back-to-back samples: running sums and throughput.
    a1 = 0;
    for (int i = 0; i < 5; i++) begin
      send(xs[i], qs[i], 1'b1, 1'b0, 0, 0, a0);
      if (i > 0) chk("accept_spacing", a0 - a1, TAPS + 2);
      a1 = a0;
    end
    drain();

    // Backpressure: result held, new sample refused until released.
    out_ready = 1'b0;
    send(5, 12, 1'b1, 1'b0, 0, 0, a0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
    end
    chk("bp_out_valid_rise", int'(out_valid), 1);
    x        = 4'd7;
    in_valid = 1'b1;
    repeat (5) begin
      step();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_q", int'(q), 12);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_idle", int'(in_ready), 1);
    chk("bp_release_ov", int'(out_valid), 0);
    send(7, 16, 1'b1, 1'b0, 0, 0, a0);
    drain();

    // Coefficient program {1,2,3,4}; c[2] written with the first accept.
    wcfg(0, 1);
    wcfg(1, 2);
    wcfg(3, 4);
    send(0, 29, 1'b1, 1'b1, 2, 3, a0);
    send(0, 41, 1'b1, 1'b0, 0, 0, a0);
    send(0, 28, 1'b1, 1'b0, 0, 0, a0);
    send(1, 1, 1'b1, 1'b0, 0, 0, a0);
    // Write attempted during MAC: rejected with a one-cycle error pulse.
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 4'd9;
    step();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    step();
    chk("cfg_err_clear", int'(cfg_err), 0);
    send(0, 2, 1'b1, 1'b0, 0, 0, a0);
    send(0, 3, 1'b1, 1'b0, 0, 0, a0);
    send(0, 4, 1'b1, 1'b0, 0, 0, a0);
    send(2, 2, 1'b1, 1'b0, 0, 0, a0);
    drain();

    // Reset two cycles after an accept: no result, state restored.
    send(9, 0, 1'b0, 1'b0, 0, 0, a0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_q", int'(q), 0);
    rst = 1'b1;
    repeat (6) begin
      step();
      chk("mid_rst_no_valid", int'(out_valid), 0);
    end
    send(5, 5, 1'b1, 1'b0, 0, 0, a0);
    send(1, 6, 1'b1, 1'b0, 0, 0, a0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
